// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite encodings, bridge state type and byte-enable decode
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } bridge_state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] hsize;
        logic [1:0] offset;
    } be_dec_t;

    // Only naturally aligned byte, halfword and word lane patterns map onto one AHB transfer.
    function automatic be_dec_t be_decode(input logic [3:0] be);
        be_dec_t d;
        d.legal  = 1'b1;
        d.hsize  = HSIZE_BYTE;
        d.offset = 2'd0;
        case (be)
            4'b1111: d.hsize = HSIZE_WORD;
            4'b0011: d.hsize = HSIZE_HALF;
            4'b1100: begin
                d.hsize  = HSIZE_HALF;
                d.offset = 2'd2;
            end
            4'b0001: d.offset = 2'd0;
            4'b0010: d.offset = 2'd1;
            4'b0100: d.offset = 2'd2;
            4'b1000: d.offset = 2'd3;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ctrbus_ahb3lite_bridge.sv
// rtl/ctrbus_ahb3lite_bridge.sv - CtrBus request channel to single-slave AHB3-Lite SINGLE transfer bridge
module ctrbus_ahb3lite_bridge
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req,
    output logic              gnt,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("ctrbus_ahb3lite_bridge supports DATA_W = 32 only");
        end
    endgenerate

    bridge_state_t     state;
    logic [ADDR_W-1:0] haddr_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rvalid_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    be_dec_t           dec;

    // The sub-word position comes from the byte enables, not from the low address bits.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign dec = be_decode(be);

    // Gated by reset so a pending request is never granted while the bridge is held in reset.
    assign gnt = req && (state == ST_IDLE) && Rst_n;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_BYTE;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        haddr_q  <= {addr[ADDR_W-1:2], dec.offset};
                        hwrite_q <= we;
                        hsize_q  <= dec.hsize;
                        wdata_q  <= wdata;
                        if (dec.legal) begin
                            state <= ST_ADDR;
                        end else begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // HRESP with HREADY low is only the first half of an error response.
                    if (HREADY) begin
                        state    <= ST_IDLE;
                        rvalid_q <= 1'b1;
                        err_q    <= HRESP;
                        if (!hwrite_q && !HRESP) begin
                            rdata_q <= HRDATA;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign HSEL      = (state == ST_ADDR);
    assign HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = wdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_ctrbus_ahb3lite_bridge.sv
// tb/tb_ctrbus_ahb3lite_bridge.sv - table-driven scoreboard bench for ctrbus_ahb3lite_bridge
module tb_ctrbus_ahb3lite_bridge;
    import ahb3lite_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        req, gnt, we, rvalid, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 Clk = ~Clk;

    ctrbus_ahb3lite_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .req(req), .gnt(gnt), .we(we), .be(be),
        .addr(addr), .wdata(wdata), .rvalid(rvalid), .rdata(rdata), .err(err),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        int          aw;
        int          dw;
        logic        hresp;
        logic        legal;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } sb_t;

    vec_t vecs[13];
    sb_t  exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] b, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] hr, input int aw,
                                input int dw, input logic hresp, input logic legal,
                                input logic [31:0] ha, input logic [2:0] hs,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.we = w; v.be = b; v.addr = a; v.wdata = wd; v.hrdata = hr;
        v.aw = aw; v.dw = dw; v.hresp = hresp; v.legal = legal;
        v.haddr = ha; v.hsize = hs; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    always @(negedge Clk) begin
        if (Rst_n && rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                check("rvalid_cycle", cyc, e.cyc);
                check("rdata", rdata, e.rdata);
                check("err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    // Entered and left at posedge+1; on return the bench sits in the rvalid cycle.
    task automatic run_vec(input int idx, input vec_t v);
        sb_t e;
        req = 1'b1; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.cyc   = cyc + (v.legal ? 3 + v.aw + v.dw : 1);
        exp_q.push_back(e);
        @(negedge Clk);
        check($sformatf("v%0d_gnt", idx), {31'd0, gnt}, 32'd1);
        check($sformatf("v%0d_htrans_t0", idx), {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
        @(posedge Clk); #1;
        // A busy bridge must ignore this competing request.
        we = 1'b0; be = 4'hF; addr = 32'hFFFF_FFF0; wdata = 32'hFFFF_FFFF;
        if (!v.legal) return;
        for (int i = 0; i <= v.aw; i++) begin
            HREADY = (i == v.aw); HRESP = 1'b0;
            @(negedge Clk);
            check($sformatf("v%0d_a%0d_hsel", idx, i), {31'd0, HSEL}, 32'd1);
            check($sformatf("v%0d_a%0d_htrans", idx, i), {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
            check($sformatf("v%0d_a%0d_haddr", idx, i), HADDR, v.haddr);
            check($sformatf("v%0d_a%0d_hsize", idx, i), {29'd0, HSIZE}, {29'd0, v.hsize});
            check($sformatf("v%0d_a%0d_hwrite", idx, i), {31'd0, HWRITE}, {31'd0, v.we});
            check($sformatf("v%0d_a%0d_gnt", idx, i), {31'd0, gnt}, 32'd0);
            @(posedge Clk); #1;
        end
        for (int i = 0; i <= v.dw; i++) begin
            HREADY = (i == v.dw);
            HRESP  = v.hresp && (i >= v.dw - 1);
            HRDATA = (i == v.dw) ? v.hrdata : 32'hBAD0_0000 + i;
            @(negedge Clk);
            check($sformatf("v%0d_d%0d_htrans", idx, i), {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
            check($sformatf("v%0d_d%0d_hsel", idx, i), {31'd0, HSEL}, 32'd0);
            check($sformatf("v%0d_d%0d_gnt", idx, i), {31'd0, gnt}, 32'd0);
            if (v.we) check($sformatf("v%0d_d%0d_hwdata", idx, i), HWDATA, v.wdata);
            @(posedge Clk); #1;
        end
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, {31'd0, gnt}, 32'd0);
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_hsel"}, {31'd0, HSEL}, 32'd0);
        check({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
        check({tag, "_haddr"}, HADDR, 32'd0);
        check({tag, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
        check({tag, "_hsize"}, {29'd0, HSIZE}, 32'd0);
        check({tag, "_hwdata"}, HWDATA, 32'd0);
        check({tag, "_hburst"}, {29'd0, HBURST}, 32'd0);
        check({tag, "_hprot"}, {28'd0, HPROT}, 32'h3);
        check({tag, "_hmastlock"}, {31'd0, HMASTLOCK}, 32'd0);
    endtask

    initial begin
        //                we    be       addr          wdata         hrdata      aw dw hresp legal haddr        hsize     rdata         err
        vecs[0]  = mk(1'b0, 4'b1111, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 1'b1, 32'h8000_0004, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
        vecs[1]  = mk(1'b1, 4'b0100, 32'h4000_0010, 32'h00AB_0000, 32'h5555_5555, 0, 2, 1'b0, 1'b1, 32'h4000_0012, HSIZE_BYTE, 32'h0, 1'b0);
        vecs[2]  = mk(1'b0, 4'b1111, 32'h4000_0020, 32'h0,        32'h1234_5678, 0, 1, 1'b1, 1'b1, 32'h4000_0020, HSIZE_WORD, 32'h0, 1'b1);
        vecs[3]  = mk(1'b0, 4'b0110, 32'h4000_0030, 32'h0,        32'h0,         0, 0, 1'b0, 1'b0, 32'h0,         HSIZE_BYTE, 32'h0, 1'b1);
        vecs[4]  = mk(1'b0, 4'b1111, 32'h0000_0000, 32'h0,        32'h1111_1111, 0, 0, 1'b0, 1'b1, 32'h0000_0000, HSIZE_WORD, 32'h1111_1111, 1'b0);
        vecs[5]  = mk(1'b0, 4'b1111, 32'h0000_0004, 32'h0,        32'h2222_2222, 0, 0, 1'b0, 1'b1, 32'h0000_0004, HSIZE_WORD, 32'h2222_2222, 1'b0);
        vecs[6]  = mk(1'b0, 4'b1100, 32'h0000_0100, 32'h0,        32'hA5A5_5A5A, 1, 0, 1'b0, 1'b1, 32'h0000_0102, HSIZE_HALF, 32'hA5A5_5A5A, 1'b0);
        vecs[7]  = mk(1'b1, 4'b1000, 32'h0000_0203, 32'hCD00_0000, 32'h5555_5555, 2, 1, 1'b0, 1'b1, 32'h0000_0203, HSIZE_BYTE, 32'h0, 1'b0);
        vecs[8]  = mk(1'b1, 4'b0011, 32'h0000_0302, 32'h0000_BEEF, 32'h5555_5555, 0, 0, 1'b0, 1'b1, 32'h0000_0300, HSIZE_HALF, 32'h0, 1'b0);
        vecs[9]  = mk(1'b1, 4'b0000, 32'h0000_0400, 32'h1234_5678, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,         HSIZE_BYTE, 32'h0, 1'b1);
        vecs[10] = mk(1'b0, 4'b0001, 32'h0000_0007, 32'h0,        32'h0000_00CC, 0, 0, 1'b0, 1'b1, 32'h0000_0004, HSIZE_BYTE, 32'h0000_00CC, 1'b0);
        vecs[11] = mk(1'b1, 4'b1111, 32'h0000_0500, 32'hCAFE_F00D, 32'h5555_5555, 0, 2, 1'b1, 1'b1, 32'h0000_0500, HSIZE_WORD, 32'h0, 1'b1);
        vecs[12] = mk(1'b0, 4'b0010, 32'h0000_0010, 32'h0,        32'h0077_0000, 1, 1, 1'b0, 1'b1, 32'h0000_0011, HSIZE_BYTE, 32'h0077_0000, 1'b0);

        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0; wdata = 32'h0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("por");
        @(posedge Clk); #1;
        Rst_n = 1'b1; req = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
        req = 1'b0;
        @(posedge Clk); #1;

        // Reset while the slave stalls the data phase: the read must vanish.
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h5000_0008; wdata = 32'h9999_9999;
        @(posedge Clk); #1;
        req = 1'b0; HREADY = 1'b1;
        @(negedge Clk);
        check("rst_addr_htrans", {30'd0, HTRANS}, {30'd0, HTRANS_NONSEQ});
        @(posedge Clk); #1;
        HREADY = 1'b0;
        @(negedge Clk);
        check("rst_data_haddr", HADDR, 32'h5000_0008);
        #1 Rst_n = 1'b0; req = 1'b1;
        #1 check_reset_outputs("midrst");
        @(posedge Clk); #1;
        check_reset_outputs("midrst_hold");
        req = 1'b0; Rst_n = 1'b1; HREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check($sformatf("post_rst_rvalid_%0d", k), {31'd0, rvalid}, 32'd0);
            check($sformatf("post_rst_htrans_%0d", k), {30'd0, HTRANS}, 32'd0);
        end
        @(posedge Clk); #1;
        run_vec(13, mk(1'b0, 4'b1111, 32'h6000_0008, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b1,
                       32'h6000_0008, HSIZE_WORD, 32'h0BAD_F00D, 1'b0));
        req = 1'b0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge Clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
